// File: rtl/matmul_pkg.sv
// Shared types for the matmul result path: output-buffer FSM states and
// an address-width helper that never collapses to zero bits.
package matmul_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } out_state_e;

  // Address bits needed for a depth; a single-entry memory still gets one bit.
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memory.sv
// Single-port result memory: synchronous write, registered (1-cycle) read.
// Addresses at or beyond SIZE neither write nor update the read register.
module memory #(
  parameter  int unsigned WIDTH = 28,
  parameter  int unsigned SIZE  = 63,
  localparam int unsigned AW    = matmul_pkg::addr_bits(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [SIZE];
  logic             in_range;

  assign in_range = 32'(addr) < SIZE;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr] <= wdata;
  end

  // Registered read port, read-before-write on the shared address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rdata <= '0;
    else if (in_range) rdata <= mem[addr];
  end

endmodule

// File: rtl/output_mems.sv
// Result buffer between the matmul datapath and an AXI-Stream sink.
// FILL accepts row-major result writes; compute_finished triggers a one-cycle
// PRIME that reads address 0, then STREAM emits M*N words in address order.
// The memory address runs one word ahead on a handshake so a continuously
// ready sink gets one word per cycle; on a stall it re-reads rd_ptr, which
// keeps TDATA stable because nothing writes the memory outside FILL.
module output_mems
  import matmul_pkg::*;
#(
  parameter  int unsigned OUTW        = 28,
  parameter  int unsigned M           = 7,
  parameter  int unsigned N           = 9,
  localparam int unsigned C_ADDR_BITS = $clog2(M*N),
  localparam int unsigned AW          = addr_bits(M*N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OUTW-1:0] C_wr_data,
  input  logic [AW-1:0]   C_wr_addr,
  input  logic            C_wr_en,
  input  logic            compute_finished,
  output logic            output_ready,
  output logic [OUTW-1:0] AXIS_TDATA,
  output logic            AXIS_TVALID,
  output logic            AXIS_TLAST,
  input  logic            AXIS_TREADY
);

  localparam int unsigned DEPTH = M * N;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  out_state_e      state;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic            handshake;

  assign handshake = AXIS_TVALID && AXIS_TREADY;

  // Single memory port: write address while filling, read pointer (or its
  // successor on a handshake) otherwise.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = rd_ptr;
    case (state)
      FILL: begin
        mem_we   = C_wr_en && (32'(C_wr_addr) < DEPTH);
        mem_addr = C_wr_addr;
      end
      STREAM: begin
        if (handshake) mem_addr = (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      end
      default: mem_addr = rd_ptr;
    endcase
  end

  memory #(
    .WIDTH (OUTW),
    .SIZE  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (C_wr_data),
    .rdata (AXIS_TDATA)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      rd_ptr       <= '0;
      output_ready <= 1'b1;
      AXIS_TVALID  <= 1'b0;
      AXIS_TLAST   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (compute_finished) begin
            state        <= PRIME;
            output_ready <= 1'b0;
          end
        end
        PRIME: begin
          state       <= STREAM;
          AXIS_TVALID <= 1'b1;
          AXIS_TLAST  <= (rd_ptr == LAST);
        end
        STREAM: begin
          if (handshake) begin
            if (rd_ptr == LAST) begin
              state        <= FILL;
              rd_ptr       <= '0;
              output_ready <= 1'b1;
              AXIS_TVALID  <= 1'b0;
              AXIS_TLAST   <= 1'b0;
            end else begin
              rd_ptr     <= rd_ptr + AW'(1);
              AXIS_TLAST <= (rd_ptr + AW'(1) == LAST);
            end
          end
        end
        default: begin
          state        <= FILL;
          rd_ptr       <= '0;
          output_ready <= 1'b1;
          AXIS_TVALID  <= 1'b0;
          AXIS_TLAST   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_mems.sv
// Directed bench for output_mems: 7x9 instance plus a 1x1 corner instance.
module tb_output_mems;

  logic        clk;
  logic        reset;
  logic [27:0] c_wr_data;
  logic [5:0]  c_wr_addr;
  logic        c_wr_en;
  logic        cf;
  logic        tready;
  logic        oready;
  logic [27:0] tdata;
  logic        tvalid;
  logic        tlast;

  logic [7:0]  s_data;
  logic [0:0]  s_addr;
  logic        s_en;
  logic        s_cf;
  logic        s_rdy;
  logic        s_oready;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;

  logic [27:0] exp_mem [63];
  int          n_chk;
  int          n_fail;

  output_mems #(.OUTW(28), .M(7), .N(9)) dut (
    .clk              (clk),
    .reset            (reset),
    .C_wr_data        (c_wr_data),
    .C_wr_addr        (c_wr_addr),
    .C_wr_en          (c_wr_en),
    .compute_finished (cf),
    .output_ready     (oready),
    .AXIS_TDATA       (tdata),
    .AXIS_TVALID      (tvalid),
    .AXIS_TLAST       (tlast),
    .AXIS_TREADY      (tready)
  );

  output_mems #(.OUTW(8), .M(1), .N(1)) dut1 (
    .clk              (clk),
    .reset            (reset),
    .C_wr_data        (s_data),
    .C_wr_addr        (s_addr),
    .C_wr_en          (s_en),
    .compute_finished (s_cf),
    .output_ready     (s_oready),
    .AXIS_TDATA       (s_tdata),
    .AXIS_TVALID      (s_tvalid),
    .AXIS_TLAST       (s_tlast),
    .AXIS_TREADY      (s_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write base+i to every address, one per cycle.
  task automatic fill(input int base);
    for (int i = 0; i < 63; i++) begin
      c_wr_en   = 1'b1;
      c_wr_addr = 6'(i);
      c_wr_data = 28'(base + i);
      exp_mem[i] = 28'(base + i);
      @(negedge clk);
    end
    c_wr_en = 1'b0;
  endtask

  // Pulse compute_finished (optionally with a write to 62) and check latency.
  task automatic start_frame(input bit wr62, input logic [27:0] d);
    chk("fill_oready", 64'(oready), 64'(1));
    chk("fill_tvalid", 64'(tvalid), 64'(0));
    if (wr62) begin
      c_wr_en   = 1'b1;
      c_wr_addr = 6'd62;
      c_wr_data = d;
      exp_mem[62] = d;
    end
    cf = 1'b1;
    @(negedge clk);
    cf      = 1'b0;
    c_wr_en = 1'b0;
    chk("prime_tvalid", 64'(tvalid), 64'(0));
    chk("prime_oready", 64'(oready), 64'(0));
    @(negedge clk);
    chk("first_tvalid", 64'(tvalid), 64'(1));
  endtask

  // Consume nwords, checking every presented word including stalled cycles.
  task automatic stream(input bit rnd, input bit junk, input int nwords);
    int  k;
    int  cyc;
    bit  rdy;
    k   = 0;
    cyc = 0;
    while (k < nwords && cyc < 4000) begin
      chk("tvalid", 64'(tvalid), 64'(1));
      chk("tdata", 64'(tdata), 64'(exp_mem[k]));
      chk("tlast", 64'(tlast), 64'(k == 62));
      rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = rdy;
      if (junk) begin
        c_wr_en   = 1'b1;
        c_wr_addr = 6'(k);
        c_wr_data = 28'h0DEAD00;
        cf        = 1'b1;
      end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    tready  = 1'b0;
    c_wr_en = 1'b0;
    cf      = 1'b0;
    chk("stream_count", 64'(k), 64'(nwords));
    if (nwords == 63) begin
      chk("end_tvalid", 64'(tvalid), 64'(0));
      chk("end_tlast", 64'(tlast), 64'(0));
      chk("end_oready", 64'(oready), 64'(1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    c_wr_data = '0; c_wr_addr = '0; c_wr_en = 1'b0; cf = 1'b0; tready = 1'b0;
    s_data = '0; s_addr = '0; s_en = 1'b0; s_cf = 1'b0; s_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_oready", 64'(oready), 64'(1));
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back stream with a continuously ready sink.
    fill(100);
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b0, 63);

    // Random back-pressure, same frame.
    start_frame(1'b0, 28'h0);
    stream(1'b1, 1'b0, 63);

    // Write to the last address in the compute_finished cycle.
    fill(100);
    start_frame(1'b1, 28'hABC);
    stream(1'b0, 1'b0, 63);

    // Writes and compute_finished during STREAM are ignored; second frame intact.
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b1, 63);
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b0, 63);

    // Out-of-range write alters nothing.
    c_wr_en = 1'b1; c_wr_addr = 6'd63; c_wr_data = 28'h5555555;
    @(negedge clk);
    c_wr_en = 1'b0;
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b0, 63);

    // Reset mid-stream while stalled at word 20.
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b0, 20);
    chk("pre_rst_tdata", 64'(tdata), 64'(exp_mem[20]));
    reset = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(tvalid), 64'(0));
    chk("midrst_tlast", 64'(tlast), 64'(0));
    chk("midrst_oready", 64'(oready), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_tvalid", 64'(tvalid), 64'(0));
    fill(200);
    start_frame(1'b0, 28'h0);
    stream(1'b0, 1'b0, 63);

    // Single-word memory.
    s_en = 1'b1; s_addr = 1'b0; s_data = 8'h77;
    @(negedge clk);
    s_en = 1'b0; s_cf = 1'b1;
    @(negedge clk);
    s_cf = 1'b0;
    chk("one_prime_tvalid", 64'(s_tvalid), 64'(0));
    chk("one_prime_oready", 64'(s_oready), 64'(0));
    @(negedge clk);
    chk("one_tvalid", 64'(s_tvalid), 64'(1));
    chk("one_tdata", 64'(s_tdata), 64'(8'h77));
    chk("one_tlast", 64'(s_tlast), 64'(1));
    s_rdy = 1'b1;
    @(negedge clk);
    s_rdy = 1'b0;
    chk("one_end_tvalid", 64'(s_tvalid), 64'(0));
    chk("one_end_oready", 64'(s_oready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/output_mems.md
OUTPUT_MEMS -- requirements
Module: output_mems

Interface
REQ-001 SHALL have parameter OUTW, default 28, meaning result word width.
REQ-002 SHALL have parameter M, default 7, meaning result matrix rows.
REQ-003 SHALL have parameter N, default 9, meaning result matrix columns.
REQ-004 SHALL derive localparam C_ADDR_BITS = $clog2(M*N), meaning result address width.
REQ-005 clk  input  1  the one clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 C_wr_data  input  OUTW  result word from compute datapath.
REQ-008 C_wr_addr  input  C_ADDR_BITS  row-major result address, row*N+col.
REQ-009 C_wr_en  input  1  write strobe for C_wr_data.
REQ-010 compute_finished  input  1  all M*N results written; start streaming.
REQ-011 output_ready  output  1  high while block accepts result writes.
REQ-012 AXIS_TDATA  output  OUTW  streamed result word.
REQ-013 AXIS_TVALID  output  1  AXIS_TDATA valid.
REQ-014 AXIS_TLAST  output  1  marks word M*N-1.
REQ-015 AXIS_TREADY  input  1  downstream accepts word.

Function
REQ-016 SHALL implement states FILL, PRIME, STREAM.
REQ-017 FILL: output_ready=1, AXIS_TVALID=0; write mem[C_wr_addr] on C_wr_en when C_wr_addr < M*N; ignore out-of-range addresses.
REQ-018 FILL->PRIME when compute_finished sampled high; a write in that same cycle SHALL be stored.
REQ-019 PRIME: one cycle, issue read of address 0, output_ready=0, AXIS_TVALID=0.
REQ-020 PRIME->STREAM unconditionally; AXIS_TVALID SHALL rise 2 cycles after the compute_finished sample edge.
REQ-021 STREAM: AXIS_TVALID=1, AXIS_TDATA=mem[rd_ptr], words in address order 0..M*N-1.
REQ-022 Handshake = TVALID&&TREADY on a rising edge; rd_ptr advances by 1 only on handshake.
REQ-023 While TVALID&&!TREADY, TDATA and TLAST SHALL hold stable, for any number of cycles.
REQ-024 With TREADY held high, SHALL sustain one word per cycle, no bubbles (next read address = rd_ptr+1 on handshake).
REQ-025 AXIS_TLAST=1 exactly when TVALID=1 and rd_ptr=M*N-1.
REQ-026 Handshake with TLAST -> FILL; rd_ptr=0; output_ready=1 next cycle.
REQ-027 C_wr_en and compute_finished outside FILL SHALL be ignored.
REQ-028 M*N=1 SHALL work: single word with TLAST=1.
REQ-029 AXIS_TDATA is don't-care while TVALID=0.

Reset
REQ-030 reset low SHALL immediately force state FILL, rd_ptr=0, AXIS_TVALID=0, AXIS_TLAST=0, output_ready=1.
REQ-031 Reset mid-STREAM SHALL abort the stream with no further words; memory contents need not be cleared.

Structure
REQ-032 State enum typedef SHALL live in shared package matmul_pkg.
REQ-033 Storage SHALL be one instance of the existing memory sub-module, WIDTH=OUTW, SIZE=M*N, single-port with 1-cycle registered read.
REQ-034 Write address muxed from C_wr_addr in FILL, read pointer otherwise.

Verification
REQ-035 Write mem[i]=i+100 for i=0..62, pulse compute_finished -> TVALID rises 2 cycles later; 63 words 100..162 on consecutive cycles with TREADY=1; TLAST only on 162.
REQ-036 Random TREADY (50%) -> same 63 words in order, TDATA/TLAST stable during every stall.
REQ-037 compute_finished coincident with write addr 62=0xABC -> last streamed word 0xABC.
REQ-038 Writes and compute_finished during STREAM -> ignored; stream unchanged; after TLAST, output_ready=1 and a second 63-word frame is correct.
REQ-039 reset low at word 20 while TREADY=0 -> TVALID=0 same cycle, output_ready=1; after release and new fill, stream restarts at address 0.
REQ-040 Write to address 63 (out of range) -> no memory location altered.
